// File: rtl/gfx_unit_prim_if.sv
// Command channel of the primitive renderer: a valid/ready handshake that carries
// the opcode, pixel mode and two signed endpoints/corners.
// master (requester): drives cmd_valid, cmd_op, cmd_mode, x0, y0, x1, y1.
// slave (renderer): returns cmd_ready.
interface gfx_unit_prim_if #(
    parameter int COORD_W = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [1:0]                cmd_mode;
    logic signed [COORD_W-1:0] x0;
    logic signed [COORD_W-1:0] y0;
    logic signed [COORD_W-1:0] x1;
    logic signed [COORD_W-1:0] y1;

    modport master (
        output cmd_valid, cmd_op, cmd_mode, x0, y0, x1, y1,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mode, x0, y0, x1, y1,
        output cmd_ready
    );
endinterface

// File: rtl/gfx_unit_prim.sv
// 2D primitive renderer (line / rect / full screen) over a page-organised
// monochrome framebuffer with a priority display read port.
// Ports: clk, resetn (sync, active low), cmd (command channel, slave side),
// disp_rd_i/disp_addr_i/disp_data_o (display read), busy_o, done_o.
module gfx_unit_prim #(
    parameter int XSIZE   = 128,
    parameter int YSIZE   = 64,
    parameter int COORD_W = 8,
    parameter int ADDR_W  = $clog2(XSIZE*YSIZE/8)
) (
    input  logic              clk,
    input  logic              resetn,
    gfx_unit_prim_if.slave    cmd,
    input  logic              disp_rd_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic [7:0]        disp_data_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int NBYTES = XSIZE*YSIZE/8;
    localparam int EW     = COORD_W + 2;
    localparam int RW     = COORD_W + 1;
    localparam int SKIP   = 2**COORD_W;

    localparam logic [1:0] OP_LINE   = 2'd0;
    localparam logic [1:0] OP_RECT   = 2'd1;
    localparam logic [1:0] OP_SCREEN = 2'd2;
    localparam logic [1:0] M_CLR     = 2'd1;
    localparam logic [1:0] M_XOR     = 2'd2;

    typedef enum logic [2:0] {
        IDLE, SETUP, LOOP_RD, LOOP_WR, SCR_RD, SCR_WR, FINISH
    } state_t;

    state_t                    state_q;
    logic [1:0]                op_q;
    logic [1:0]                mode_q;
    logic signed [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic signed [COORD_W-1:0] px_q, py_q;
    logic signed [COORD_W-1:0] xlo_q, xhi_q, yhi_q;
    logic signed [EW-1:0]      dx_q, dy_q, err_q;
    logic                      sxn_q, syn_q;
    logic [RW-1:0]             rem_q;
    logic [ADDR_W-1:0]         sa_q;
    logic [7:0]                byte_q;
    logic [7:0]                disp_q;
    logic                      ready_q, busy_q, done_q;
    logic [7:0]                mem [NBYTES];

    assign cmd.cmd_ready = ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign disp_data_o   = disp_q;

    function automatic logic vis(input int x, input int y);
        return x >= 0 && x < XSIZE && y >= 0 && y < YSIZE;
    endfunction

    function automatic logic [ADDR_W-1:0] baddr(input int x, input int y);
        int a;
        a = (y >>> 3) * XSIZE + x;
        return a[ADDR_W-1:0];
    endfunction

    function automatic void bstep(
        input int dx, input int dy, input int sx, input int sy,
        inout int x, inout int y, inout int e
    );
        int e2;
        e2 = 2 * e;
        if (e2 >= -dy) begin
            e = e - dy;
            x = x + sx;
        end
        if (e2 <= dx) begin
            e = e + dx;
            y = y + sy;
        end
    endfunction

    // Line setup: the visible part of a line is one contiguous run, so the
    // leading off-screen pixels are traced away here and cost no cycles.
    int   ldx, ldy, lsx, lsy, lx, ly, le, lr;
    logic lfound;
    always_comb begin
        ldx = int'(x1_q) - int'(x0_q);
        ldy = int'(y1_q) - int'(y0_q);
        lsx = (ldx < 0) ? -1 : 1;
        lsy = (ldy < 0) ? -1 : 1;
        if (ldx < 0) ldx = -ldx;
        if (ldy < 0) ldy = -ldy;
        lx = int'(x0_q);
        ly = int'(y0_q);
        le = ldx - ldy;
        lr = (ldx > ldy) ? ldx : ldy;
        for (int i = 0; i < SKIP; i++) begin
            if (!vis(lx, ly) && lr > 0) begin
                bstep(ldx, ldy, lsx, lsy, lx, ly, le);
                lr = lr - 1;
            end
        end
        lfound = vis(lx, ly);
    end

    int nx, ny, ne;
    always_comb begin
        nx = int'(px_q);
        ny = int'(py_q);
        ne = int'(err_q);
        bstep(int'(dx_q), int'(dy_q), sxn_q ? -1 : 1, syn_q ? -1 : 1,
              nx, ny, ne);
    end

    int   rxl, rxh, ryl, ryh;
    logic rempty;
    always_comb begin
        rxl = (x0_q < x1_q) ? int'(x0_q) : int'(x1_q);
        rxh = (x0_q < x1_q) ? int'(x1_q) : int'(x0_q);
        ryl = (y0_q < y1_q) ? int'(y0_q) : int'(y1_q);
        ryh = (y0_q < y1_q) ? int'(y1_q) : int'(y0_q);
        if (rxl < 0) rxl = 0;
        if (ryl < 0) ryl = 0;
        if (rxh > XSIZE-1) rxh = XSIZE-1;
        if (ryh > YSIZE-1) ryh = YSIZE-1;
        rempty = (rxl > rxh) || (ryl > ryh);
    end

    // Screen fill uses a full-byte mask so SET/CLR/XOR share the pixel path.
    logic              scr;
    logic [ADDR_W-1:0] wa;
    logic [7:0]        mask;
    logic [7:0]        wdata;
    logic              we;
    always_comb begin
        scr  = (state_q == SCR_RD) || (state_q == SCR_WR);
        wa   = scr ? sa_q : baddr(int'(px_q), int'(py_q));
        mask = scr ? 8'hFF : (8'h01 << py_q[2:0]);
        unique case (1'b1)
            mode_q == M_CLR: wdata = byte_q & ~mask;
            mode_q == M_XOR: wdata = byte_q ^ mask;
            default:         wdata = byte_q | mask;
        endcase
        we = resetn && !disp_rd_i &&
             ((state_q == LOOP_WR) || (state_q == SCR_WR));
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= 8'h00;
            op_q    <= '0;
            mode_q  <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            xlo_q   <= '0;
            xhi_q   <= '0;
            yhi_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sxn_q   <= 1'b0;
            syn_q   <= 1'b0;
            rem_q   <= '0;
            sa_q    <= '0;
            byte_q  <= '0;
        end else begin
            if (disp_rd_i) disp_q <= mem[disp_addr_i];
            unique case (state_q)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q    <= cmd.cmd_op;
                        mode_q  <= cmd.cmd_mode;
                        x0_q    <= cmd.x0;
                        y0_q    <= cmd.y0;
                        x1_q    <= cmd.x1;
                        y1_q    <= cmd.y1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    unique case (1'b1)
                        op_q == OP_LINE: begin
                            dx_q  <= EW'(ldx);
                            dy_q  <= EW'(ldy);
                            sxn_q <= lsx < 0;
                            syn_q <= lsy < 0;
                            px_q  <= COORD_W'(lx);
                            py_q  <= COORD_W'(ly);
                            err_q <= EW'(le);
                            rem_q <= RW'(lr);
                            if (lfound) begin
                                state_q <= LOOP_RD;
                            end else begin
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                            end
                        end
                        op_q == OP_RECT: begin
                            xlo_q <= COORD_W'(rxl);
                            xhi_q <= COORD_W'(rxh);
                            yhi_q <= COORD_W'(ryh);
                            px_q  <= COORD_W'(rxl);
                            py_q  <= COORD_W'(ryl);
                            if (rempty) begin
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= LOOP_RD;
                            end
                        end
                        op_q == OP_SCREEN: begin
                            sa_q    <= '0;
                            state_q <= SCR_RD;
                        end
                        default: begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end
                    endcase
                end
                LOOP_RD: begin
                    if (!disp_rd_i) begin
                        byte_q  <= mem[wa];
                        state_q <= LOOP_WR;
                    end
                end
                LOOP_WR: begin
                    if (!disp_rd_i) begin
                        state_q <= LOOP_RD;
                        if (op_q == OP_LINE) begin
                            // Leaving the screen ends the visible run.
                            if (rem_q == '0 || !vis(nx, ny)) begin
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                px_q  <= COORD_W'(nx);
                                py_q  <= COORD_W'(ny);
                                err_q <= EW'(ne);
                                rem_q <= rem_q - RW'(1);
                            end
                        end else if (px_q == xhi_q) begin
                            if (py_q == yhi_q) begin
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                px_q <= xlo_q;
                                py_q <= py_q + COORD_W'(1);
                            end
                        end else begin
                            px_q <= px_q + COORD_W'(1);
                        end
                    end
                end
                SCR_RD: begin
                    if (!disp_rd_i) begin
                        byte_q  <= mem[wa];
                        state_q <= SCR_WR;
                    end
                end
                SCR_WR: begin
                    if (!disp_rd_i) begin
                        if (sa_q == ADDR_W'(NBYTES-1)) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            sa_q    <= sa_q + ADDR_W'(1);
                            state_q <= SCR_RD;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gfx_unit_prim.md
# gfx_unit_prim

Parametrised 2D primitive renderer owning a page-organised monochrome framebuffer (SSD1306 layout: byte = 8 vertical pixels, page = y/8). It accepts one command at a time to draw a Bresenham line, fill a rectangle, or fill the whole screen, using SET, CLR or XOR pixel modes with clipping to the screen. A display-side read port gives the I2C/OLED streamer priority access to the buffer.

## Interface
- XSIZE, 128, screen width in pixels (power of 2)
- YSIZE, 64, screen height in pixels (multiple of 8)
- COORD_W, 8, signed coordinate width
- ADDR_W, $clog2(XSIZE*YSIZE/8), framebuffer byte address width
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_op  in  2  0 LINE, 1 RECT, 2 SCREEN, 3 reserved (accepted, no writes, done pulses)
- cmd_mode  in  2  0 SET, 1 CLR, 2 XOR, 3 treated as SET
- x0, y0, x1, y1  in  COORD_W each  signed endpoints/corners
- disp_rd  in  1  display read strobe
- disp_addr  in  ADDR_W  display byte address
- disp_data  out  8  read data, valid cycle after disp_rd
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SETUP, LOOP_RD, LOOP_WR, SCR_RD, SCR_WR, FINISH.
- Accept on cmd_valid && cmd_ready; all command fields captured that cycle; inputs ignored afterwards.
- Byte address = (y>>3)*XSIZE + x; bit = y & 7. Update: SET out|bit, CLR out&~bit, XOR out^bit.
- LINE: SETUP computes dx=|x1-x0|, dy=|y1-y0|, sx/sy=±1, err=dx-dy (width COORD_W+2, signed). Classic integer Bresenham; both endpoints drawn; N = max(dx,dy)+1 pixels, each pixel exactly once.
- RECT: SETUP normalises corners (min/max), clips to [0,XSIZE-1]×[0,YSIZE-1]; raster order x inner, y outer; fully off-screen rect draws nothing.
- SCREEN: every byte 0..XSIZE*YSIZE/8-1 in order: SET writes 0xFF, CLR 0x00, XOR inverts byte.
- Clipping: pixel with x or y outside screen skips its read and write (no cycles spent on it) but line tracing continues.
- Each pixel/byte is read-modify-write: LOOP_RD issues RAM read, LOOP_WR writes updated byte.
- disp_rd has priority: in any cycle with disp_rd high the RAM port serves the display; a pending draw read or write stalls one cycle (state held). disp_rd during IDLE always valid.
- FINISH: done=1 for one cycle, return to IDLE.
- Reset mid-command: abort immediately, IDLE, no further writes; framebuffer contents not cleared by reset.

## Timing
- Reset values: cmd_ready=1 (after reset cycle), busy=0, done=0, disp_data=0.
- Accept at cycle 0; SETUP cycle 1; first read cycle 2; per on-screen pixel 2 cycles; done high at cycle 2+2P, P = on-screen pixels (no stalls). cmd_ready high again cycle 3+2P.
- SCREEN: done at cycle 2+2·(XSIZE*YSIZE/8) for all modes.
- Each disp_rd stall adds exactly 1 cycle.
- disp_data registered, 1-cycle read latency; read-during-draw-write returns data after that write only if issued the cycle after.

## Test plan
- Reset, then SCREEN/CLR: done at cycle 2050 (128×64); all 1024 bytes read 0x00 via disp_rd.
- LINE SET (0,0)-(7,0): bytes 0..7 = 0x01, byte 8 = 0x00; done at cycle 18.
- LINE SET (0,0)-(7,7) then same with XOR: after first, byte k = 1<<k for k=0..7; after second all 0x00.
- LINE SET (-4,-4)-(3,3): only bytes 0..3 = 0x01,0x02,0x04,0x08; done at cycle 10; no other byte touched.
- RECT SET (4,10)-(2,5): bytes 2..4 = 0xE0, bytes 130..132 = 0x07; done at cycle 38.
- LINE during continuous disp_rd bursts of 3 cycles, plus resetn low mid-line: stalls add exactly 3 cycles per burst; after reset busy=0, only pixels written before reset present.
